// File: rtl/audio_out_pkg.sv
// Shared register map and bit positions for the audio output port.
package audio_out_pkg;

    localparam logic [1:0] AO_DATA   = 2'd0;
    localparam logic [1:0] AO_STATUS = 2'd1;
    localparam logic [1:0] AO_CTRL   = 2'd2;
    localparam logic [1:0] AO_RSVD   = 2'd3;

    localparam int ST_EMPTY    = 8;
    localparam int ST_FULL     = 9;
    localparam int ST_UNDERRUN = 10;
    localparam int ST_OVERFLOW = 11;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_CLR_UNDER = 1;
    localparam int CTRL_CLR_OVER  = 2;
    localparam int CTRL_FLUSH     = 3;

    function automatic logic [31:0] pack_status(
        input logic [7:0] count,
        input logic       empty,
        input logic       full,
        input logic       underrun,
        input logic       overflow
    );
        logic [31:0] s;
        s              = '0;
        s[7:0]         = count;
        s[ST_EMPTY]    = empty;
        s[ST_FULL]     = full;
        s[ST_UNDERRUN] = underrun;
        s[ST_OVERFLOW] = overflow;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array FIFO with fall-through dout; a pop frees a slot for a same-cycle push
// even when full, and flush overrides both.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/audio_out_port.sv
// Bus-fed sample FIFO drained by synchronised rising edges of an async request pin;
// bus reads have one cycle of latency, a request pops two cycles after its first sample.
module audio_out_port
    import audio_out_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [31:0]         wd,
    output logic [31:0]         rd,
    input  logic                req,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_strobe,
    output logic                irq_low
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]          reg_sel;
    logic                wr_data, wr_ctrl, flush;
    logic                sync1_q, sync2_q, sync2_dly_q, req_edge;
    logic                pop_fire, underrun_set, overflow_set;
    logic                enable_q, enable_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                strobe_q, strobe_d;
    logic [31:0]         rd_q, rd_d;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full, fifo_empty;
    logic                unused_bits;

    assign unused_bits = ^{addr, wd};

    assign reg_sel  = addr[3:2];
    assign wr_data  = we & (reg_sel == AO_DATA);
    assign wr_ctrl  = we & (reg_sel == AO_CTRL);
    assign flush    = wr_ctrl & wd[CTRL_FLUSH];
    assign req_edge = sync2_q & ~sync2_dly_q;

    // Edges only matter while enabled; a flush in the same cycle wins over the pop.
    assign pop_fire     = req_edge & enable_q & ~fifo_empty & ~flush;
    assign underrun_set = req_edge & enable_q & fifo_empty;
    assign overflow_set = wr_data & fifo_full & ~pop_fire & ~flush;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (pop_fire),
        .flush (flush),
        .din   (wd[SAMPLE_W-1:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        enable_d   = wr_ctrl ? wd[CTRL_EN] : enable_q;
        underrun_d = underrun_set | (underrun_q & ~(wr_ctrl & wd[CTRL_CLR_UNDER]));
        overflow_d = overflow_set | (overflow_q & ~(wr_ctrl & wd[CTRL_CLR_OVER]));
        sample_d   = pop_fire ? fifo_dout : sample_q;
        strobe_d   = pop_fire;
        rd_d       = '0;
        case (reg_sel)
            AO_STATUS: rd_d = pack_status(8'(fifo_count), fifo_empty, fifo_full,
                                          underrun_q, overflow_q);
            AO_CTRL:   rd_d[CTRL_EN] = enable_q;
            default:   rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
            enable_q    <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            sample_q    <= '0;
            strobe_q    <= 1'b0;
            rd_q        <= '0;
        end else begin
            sync1_q     <= req;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
            enable_q    <= enable_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            sample_q    <= sample_d;
            strobe_q    <= strobe_d;
            rd_q        <= rd_d;
        end
    end

    assign rd            = rd_q;
    assign sample_out    = sample_q;
    assign sample_strobe = strobe_q;
    assign irq_low       = enable_q & (fifo_count <= CW'(DEPTH / 4));

endmodule
